ysyx_2022040010_mem_arbiter: RTL and testbench

Shares the single core memory port between instruction fetch (IF) and load/store (LS). It runs one transaction at a time, granting LS ahead of IF by default. Read data returns one cycle after the bus response. The block drives the per-source stall requests consumed by the pipeline stall unit, and on a pipeline flush it discards the in-flight IF response.

---
 rtl/ysyx_2022040010_mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_ysyx_2022040010_mem_arbiter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_2022040010_mem_arbiter.sv
// Single-port memory arbiter between IF and LS, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN to alternate ties; otherwise LS always wins.
module ysyx_2022040010_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req_valid,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_ready,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stallreq_for_if,
  output logic                stallreq_for_ls
);

  localparam int MASK_W = DATA_W / 8;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_e;

  state_e              state_q;
  logic                owner_q;
  logic                if_pend_q;
  logic                ls_pend_q;
  logic                drop_q;
  logic                mem_vld_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [MASK_W-1:0]   mem_wmask_q;
  logic                if_rvld_q;
  logic                ls_rvld_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   ls_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
  logic                last_q;
`endif

  logic grant;
  logic pick_ls;
  logic ls_gnt;
  logic if_gnt;
  logic if_busy;
  logic kill;
  logic rsp_done;

  always_comb begin
    pick_ls = 1'b0;
    grant   = 1'b0;
    if (state_q == S_IDLE) begin
      grant = ls_req_valid | if_req_valid;
`ifdef ARB_ROUND_ROBIN_EN
      if (ls_req_valid && if_req_valid)
        pick_ls = (last_q == OWN_IF);
      else
        pick_ls = ls_req_valid;
`else
      pick_ls = ls_req_valid;
`endif
    end
  end

  assign ls_gnt   = grant & pick_ls;
  assign if_gnt   = grant & ~pick_ls;
  assign if_busy  = if_gnt |
                    ((state_q != S_IDLE) && (owner_q == OWN_IF));
  assign kill     = flush & if_busy;
  assign rsp_done = (state_q == S_WAIT) & mem_rsp_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      if_pend_q   <= 1'b0;
      ls_pend_q   <= 1'b0;
      drop_q      <= 1'b0;
      mem_vld_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      if_rvld_q   <= 1'b0;
      ls_rvld_q   <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q      <= OWN_IF;
`endif
    end else begin
      if_rvld_q <= 1'b0;
      ls_rvld_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (grant) begin
            state_q     <= S_REQ;
            owner_q     <= pick_ls;
            mem_vld_q   <= 1'b1;
            mem_we_q    <= ls_gnt & ls_we;
            mem_addr_q  <= ls_gnt ? ls_addr : if_addr;
            mem_wdata_q <= ls_gnt ? ls_wdata : '0;
            mem_wmask_q <= ls_gnt ? ls_wmask : '0;
            if_pend_q   <= if_pend_q | if_gnt;
            ls_pend_q   <= ls_pend_q | ls_gnt;
`ifdef ARB_ROUND_ROBIN_EN
            last_q      <= pick_ls;
`endif
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            state_q   <= S_WAIT;
            mem_vld_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (mem_rsp_valid) begin
            state_q <= S_IDLE;
            if (owner_q == OWN_LS) begin
              ls_rdata_q <= mem_rdata;
              ls_rvld_q  <= 1'b1;
              ls_pend_q  <= 1'b0;
            end else if (!drop_q && !flush) begin
              if_rdata_q <= mem_rdata;
              if_rvld_q  <= 1'b1;
              if_pend_q  <= 1'b0;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // A flushed IF fetch still runs on the bus; only its reply is discarded.
      if (kill) begin
        drop_q    <= 1'b1;
        if_pend_q <= 1'b0;
      end
      if (rsp_done)
        drop_q <= 1'b0;
    end
  end

  assign if_ready        = if_gnt;
  assign ls_ready        = ls_gnt;
  assign if_rvalid       = if_rvld_q;
  assign ls_rvalid       = ls_rvld_q;
  assign if_rdata        = if_rdata_q;
  assign ls_rdata        = ls_rdata_q;
  assign mem_req_valid   = mem_vld_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_wmask       = mem_wmask_q;
  assign stallreq_for_if = if_req_valid | if_pend_q;
  assign stallreq_for_ls = ls_req_valid | ls_pend_q;

endmodule

// File: tb/tb_ysyx_2022040010_mem_arbiter.sv
// Directed bench for the IF/LS memory arbiter.
// Tie expectations follow ARB_ROUND_ROBIN_EN when it is defined.
module tb_ysyx_2022040010_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_req_valid;
  logic [31:0] if_addr;
  logic        if_ready;
  logic        if_rvalid;
  logic [63:0] if_rdata;
  logic        ls_req_valid;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [63:0] ls_wdata;
  logic [7:0]  ls_wmask;
  logic        ls_ready;
  logic        ls_rvalid;
  logic [63:0] ls_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rdata;
  logic        stallreq_for_if;
  logic        stallreq_for_ls;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_2022040010_mem_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req_valid(if_req_valid), .if_addr(if_addr),
    .if_ready(if_ready), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_we(ls_we), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_wmask(ls_wmask), .ls_ready(ls_ready),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata(mem_rdata),
    .stallreq_for_if(stallreq_for_if), .stallreq_for_ls(stallreq_for_ls)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    flush = 0; if_req_valid = 0; if_addr = '0;
    ls_req_valid = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0;
    ls_wmask = '0; mem_req_ready = 0; mem_rsp_valid = 0;
    mem_rdata = '0;
  endtask

  task automatic reset_dut;
    rst = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  // Called in the REQ cycle; returns in the cycle rvalid is visible.
  task automatic bus_complete(input logic [63:0] d);
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    mem_rsp_valid = 1;
    mem_rdata = d;
    tick();
    mem_rsp_valid = 0;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    rst = 0;
    clear_inputs();
    #3;
    v = {if_ready, if_rvalid, ls_ready, ls_rvalid, mem_req_valid,
         mem_we, stallreq_for_if, stallreq_for_ls};
    checks++;
    if (v !== 8'h00) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000000", v);
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_wmask, if_rdata, ls_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h/%h/%h/%h expected 0",
               mem_addr, mem_wdata, mem_wmask, if_rdata, ls_rdata);
    end
    reset_dut();
  endtask

  task automatic test_ls_read;
    reset_dut();
    ls_req_valid = 1; ls_we = 0; ls_addr = 32'h8000_0010;
    ls_wmask = 8'hFF;
    #1;
    checks++;
    if ({ls_ready, if_ready, stallreq_for_ls} !== 3'b101) begin
      errors++;
      $display("FAIL ls_grant: got %b expected 101",
               {ls_ready, if_ready, stallreq_for_ls});
    end
    tick();
    ls_req_valid = 0; mem_req_ready = 1;
    #1;
    checks++;
    if ({mem_req_valid, mem_we, mem_addr, stallreq_for_ls, ls_ready}
        !== {1'b1, 1'b0, 32'h8000_0010, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ls_req: got v=%b we=%b a=%h st=%b rdy=%b expected 1 0 80000010 1 0",
               mem_req_valid, mem_we, mem_addr, stallreq_for_ls, ls_ready);
    end
    tick();
    mem_req_ready = 0;
    #1;
    checks++;
    if ({mem_req_valid, stallreq_for_ls, ls_rvalid} !== 3'b010) begin
      errors++;
      $display("FAIL ls_wait: got %b expected 010",
               {mem_req_valid, stallreq_for_ls, ls_rvalid});
    end
    tick();
    mem_rsp_valid = 1; mem_rdata = 64'h1122_3344_5566_7788;
    #1;
    checks++;
    if ({ls_rvalid, stallreq_for_ls} !== 2'b01) begin
      errors++;
      $display("FAIL ls_rsp_cycle: got %b expected 01",
               {ls_rvalid, stallreq_for_ls});
    end
    tick();
    mem_rsp_valid = 0; mem_rdata = '0;
    #1;
    checks++;
    if ({ls_rvalid, ls_rdata, stallreq_for_ls, if_rvalid}
        !== {1'b1, 64'h1122_3344_5566_7788, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ls_rvalid: got v=%b d=%h st=%b ifv=%b expected 1 1122334455667788 0 0",
               ls_rvalid, ls_rdata, stallreq_for_ls, if_rvalid);
    end
    tick();
    checks++;
    if ({ls_rvalid, ls_rdata} !== {1'b0, 64'h1122_3344_5566_7788}) begin
      errors++;
      $display("FAIL ls_pulse_hold: got v=%b d=%h expected 0 1122334455667788",
               ls_rvalid, ls_rdata);
    end
  endtask

  task automatic test_tie;
    reset_dut();
    if_req_valid = 1; if_addr = 32'h8000_0000;
    ls_req_valid = 1; ls_we = 1; ls_addr = 32'h8000_0100;
    ls_wdata = 64'hDEAD_BEEF_CAFE_F00D; ls_wmask = 8'h0F;
    #1;
    checks++;
    if ({ls_ready, if_ready} !== 2'b10) begin
      errors++;
      $display("FAIL tie1_ls_first: got %b expected 10", {ls_ready, if_ready});
    end
    tick();
    ls_req_valid = 0; ls_we = 0;
    #1;
    checks++;
    if ({mem_we, mem_addr, mem_wdata, mem_wmask, if_ready}
        !== {1'b1, 32'h8000_0100, 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, 1'b0}) begin
      errors++;
      $display("FAIL tie1_write_fields: got we=%b a=%h d=%h m=%h ifr=%b",
               mem_we, mem_addr, mem_wdata, mem_wmask, if_ready);
    end
    bus_complete(64'h0);
    #1;
    checks++;
    if ({ls_rvalid, ls_ready, if_ready} !== 3'b101) begin
      errors++;
      $display("FAIL tie1_if_at_rvalid: got %b expected 101",
               {ls_rvalid, ls_ready, if_ready});
    end
    tick();
    if_addr = 32'h8000_0008;
    ls_req_valid = 1; ls_addr = 32'h8000_0200;
    #1;
    checks++;
    if ({mem_addr, mem_we, mem_wmask} !== {32'h8000_0000, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL tie1_if_fields: got a=%h we=%b m=%h expected 80000000 0 00",
               mem_addr, mem_we, mem_wmask);
    end
    bus_complete(64'hA5A5_5A5A_0123_4567);
    #1;
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b1, 64'hA5A5_5A5A_0123_4567}) begin
      errors++;
      $display("FAIL tie2_if_data: got v=%b d=%h expected 1 a5a55a5a01234567",
               if_rvalid, if_rdata);
    end
    checks++;
    if ({ls_ready, if_ready} !== 2'b10) begin
      errors++;
      $display("FAIL tie2_ls: got %b expected 10", {ls_ready, if_ready});
    end
    tick();
    ls_addr = 32'h8000_0300;
    bus_complete(64'h0F0F_0F0F_F0F0_F0F0);
    #1;
    checks++;
    if ({ls_rvalid, ls_rdata} !== {1'b1, 64'h0F0F_0F0F_F0F0_F0F0}) begin
      errors++;
      $display("FAIL tie2_ls_data: got v=%b d=%h expected 1 0f0f0f0ff0f0f0f0",
               ls_rvalid, ls_rdata);
    end
    checks++;
`ifdef ARB_ROUND_ROBIN_EN
    if ({ls_ready, if_ready} !== 2'b01) begin
      errors++;
      $display("FAIL tie3_rr: got %b expected 01", {ls_ready, if_ready});
    end
`else
    if ({ls_ready, if_ready} !== 2'b10) begin
      errors++;
      $display("FAIL tie3_fixed: got %b expected 10", {ls_ready, if_ready});
    end
`endif
  endtask

  task automatic test_flush;
    reset_dut();
    if_req_valid = 1; if_addr = 32'h8000_0040;
    #1;
    checks++;
    if (if_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_if_grant: got %b expected 1", if_ready);
    end
    tick();
    if_req_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0; flush = 1;
    #1;
    checks++;
    if (stallreq_for_if !== 1'b1) begin
      errors++;
      $display("FAIL flush_stall_before: got %b expected 1", stallreq_for_if);
    end
    tick();
    flush = 0;
    #1;
    checks++;
    if (stallreq_for_if !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall_after: got %b expected 0", stallreq_for_if);
    end
    if_req_valid = 1; if_addr = 32'h8000_0048;
    #1;
    checks++;
    if (if_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_no_early_grant: got %b expected 0", if_ready);
    end
    tick();
    mem_rsp_valid = 1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    mem_rsp_valid = 0;
    #1;
    checks++;
    if ({if_rvalid, if_ready} !== 2'b01) begin
      errors++;
      $display("FAIL flush_dropped: got rv/rdy=%b expected 01",
               {if_rvalid, if_ready});
    end
    tick();
    if_req_valid = 0;
    #1;
    checks++;
    if ({if_rvalid, mem_req_valid, mem_addr} !== {1'b0, 1'b1, 32'h8000_0048}) begin
      errors++;
      $display("FAIL flush_next_req: got rv=%b v=%b a=%h expected 0 1 80000048",
               if_rvalid, mem_req_valid, mem_addr);
    end
    bus_complete(64'h1357_9BDF_2468_ACE0);
    #1;
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b1, 64'h1357_9BDF_2468_ACE0}) begin
      errors++;
      $display("FAIL flush_recover: got v=%b d=%h expected 1 13579bdf2468ace0",
               if_rvalid, if_rdata);
    end
    tick();
    if_req_valid = 1; if_addr = 32'h8000_0050; flush = 1;
    #1;
    checks++;
    if (if_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_grant_stands: got %b expected 1", if_ready);
    end
    tick();
    flush = 0; if_req_valid = 0;
    #1;
    checks++;
    if ({stallreq_for_if, mem_req_valid} !== 2'b01) begin
      errors++;
      $display("FAIL flush_grant_cycle: got st/v=%b expected 01",
               {stallreq_for_if, mem_req_valid});
    end
    bus_complete(64'h7777_7777_7777_7777);
    #1;
    checks++;
    if (if_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL flush_grant_drop: got %b expected 0", if_rvalid);
    end
    ls_req_valid = 1; ls_we = 0; ls_addr = 32'h8000_0060;
    tick();
    ls_req_valid = 0; flush = 1;
    tick();
    flush = 0;
    #1;
    checks++;
    if ({stallreq_for_ls, mem_req_valid} !== 2'b11) begin
      errors++;
      $display("FAIL flush_ls_unaffected: got %b expected 11",
               {stallreq_for_ls, mem_req_valid});
    end
    bus_complete(64'h6666_5555_4444_3333);
    #1;
    checks++;
    if ({ls_rvalid, ls_rdata} !== {1'b1, 64'h6666_5555_4444_3333}) begin
      errors++;
      $display("FAIL flush_ls_rvalid: got v=%b d=%h expected 1 6666555544443333",
               ls_rvalid, ls_rdata);
    end
  endtask

  task automatic test_backpressure;
    reset_dut();
    ls_req_valid = 1; ls_we = 1; ls_addr = 32'h8000_0080;
    ls_wdata = 64'h0123_4567_89AB_CDEF; ls_wmask = 8'hF0;
    tick();
    ls_req_valid = 0; ls_we = 0; ls_wdata = '0; ls_wmask = '0;
    if_req_valid = 1; if_addr = 32'h8000_0004;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if ({mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask, if_ready}
          !== {1'b1, 1'b1, 32'h8000_0080, 64'h0123_4567_89AB_CDEF, 8'hF0, 1'b0}) begin
        errors++;
        $display("FAIL bp_stable[%0d]: got v=%b we=%b a=%h d=%h m=%h ifr=%b",
                 i, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask, if_ready);
      end
      tick();
    end
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    #1;
    checks++;
    if ({mem_req_valid, if_ready} !== 2'b00) begin
      errors++;
      $display("FAIL bp_wait: got %b expected 00", {mem_req_valid, if_ready});
    end
    mem_rsp_valid = 1;
    tick();
    mem_rsp_valid = 0;
    #1;
    checks++;
    if ({ls_rvalid, if_ready} !== 2'b11) begin
      errors++;
      $display("FAIL bp_done: got %b expected 11", {ls_rvalid, if_ready});
    end
  endtask

  task automatic test_async_reset;
    reset_dut();
    ls_req_valid = 1; ls_addr = 32'h8000_0090;
    tick();
    ls_req_valid = 0;
    bus_complete(64'hFEED_FACE_0000_1111);
    ls_req_valid = 1; ls_we = 1; ls_addr = 32'h8000_00A0;
    ls_wdata = 64'h5555_AAAA_5555_AAAA; ls_wmask = 8'hFF;
    tick();
    ls_req_valid = 0; ls_we = 0;
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    #2 rst = 0;
    #1;
    checks++;
    if ({mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
         ls_rdata, ls_rvalid, stallreq_for_ls} !== '0) begin
      errors++;
      $display("FAIL async_reset: got v=%b we=%b a=%h d=%h m=%h rd=%h rv=%b st=%b",
               mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
               ls_rdata, ls_rvalid, stallreq_for_ls);
    end
    @(negedge clk);
    rst = 1;
    mem_rsp_valid = 1; mem_rdata = 64'h9999_9999_9999_9999;
    tick();
    mem_rsp_valid = 0;
    #1;
    checks++;
    if ({ls_rvalid, if_rvalid, mem_req_valid, ls_rdata} !== '0) begin
      errors++;
      $display("FAIL stale_rsp: got lv=%b iv=%b v=%b rd=%h expected all 0",
               ls_rvalid, if_rvalid, mem_req_valid, ls_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_ls_read();
    test_tie();
    test_flush();
    test_backpressure();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
